// File: rtl/rr_encode8.sv
// Round-robin 8-to-3 event encoder: latches request pulses into a pending register
// and drains them one binary code at a time through a valid/ready output.
module rr_encode8 #(
    parameter int N_REQ = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       out_code,
    output logic [3:0]       pend_cnt,
    output logic             overrun
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d, load_mask;
    logic [2:0]       ptr_q, ptr_d, code_q, code_d;
    logic [2:0]       sel_idx, idx;
    logic             sel_found, grant;
    logic [3:0]       cnt_q, cnt_d;
    logic             overrun_q, overrun_d;

    // Scan from ptr downward so the closest index to ptr is the last one written.
    always_comb begin
        sel_idx   = 3'd0;
        sel_found = 1'b0;
        idx       = 3'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (pending_q[idx]) begin
                sel_idx   = idx;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (sel_found) grant = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            code_d = sel_idx;
            ptr_d  = sel_idx + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign load_mask[gi] = grant && (sel_idx == 3'(gi));
        end
    endgenerate

    // A new request on the bit being granted this cycle wins over the clear.
    assign pending_d = (pending_q & ~load_mask) | req_in;
    assign overrun_d = overrun_q | (|(req_in & pending_q & ~load_mask));

    always_comb begin
        cnt_d = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d = cnt_d + {3'd0, pending_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= 3'd0;
            code_q    <= 3'd0;
            cnt_q     <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_code  = code_q;
    assign pend_cnt  = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rr_encode8.sv
// Directed bench for rr_encode8: inputs driven and outputs sampled 1 time unit after
// each rising edge, every expectation hand-computed.
module tb_rr_encode8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_code;
    logic [3:0] pend_cnt;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    rr_encode8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pend_cnt  (pend_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] c,
                           input logic [3:0] n, input logic o);
        chk({tag, ".valid"},   {7'd0, out_valid}, {7'd0, v});
        chk({tag, ".code"},    {5'd0, out_code},  {5'd0, c});
        chk({tag, ".cnt"},     {4'd0, pend_cnt},  {4'd0, n});
        chk({tag, ".overrun"}, {7'd0, overrun},   {7'd0, o});
        $display("step %-10s valid=%0d code=%0d cnt=%0d overrun=%0d",
                 tag, out_valid, out_code, pend_cnt, overrun);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_in    = 8'h00;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        chk_out("rst_async", 0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out("idle", 0, 0, 0, 0);
        end

        // Single event on line 5: ptr becomes 6
        out_ready = 1'b1;
        req_in = 8'h20; tick(); chk_out("single_a", 0, 0, 1, 0);
        req_in = 8'h00; tick(); chk_out("single_b", 1, 5, 0, 0);
        tick();                 chk_out("single_c", 0, 5, 0, 0);

        // Round robin from ptr=6 with wrap
        req_in = 8'hC3; tick(); chk_out("rr_load", 0, 5, 4, 0);
        req_in = 8'h00; tick(); chk_out("rr_6", 1, 6, 3, 0);
        tick();                 chk_out("rr_7", 1, 7, 2, 0);
        tick();                 chk_out("rr_0", 1, 0, 1, 0);
        tick();                 chk_out("rr_1", 1, 1, 0, 0);
        tick();                 chk_out("rr_end", 0, 1, 0, 0);

        // Backpressure, from a fresh pointer of 0
        do_reset();
        out_ready = 1'b0;
        req_in = 8'h05; tick(); chk_out("bp_load", 0, 0, 2, 0);
        req_in = 8'h00; tick(); chk_out("bp_hold", 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();             chk_out("bp_hold", 1, 0, 1, 0);
        end
        out_ready = 1'b1;
        tick();                 chk_out("bp_2", 1, 2, 0, 0);
        tick();                 chk_out("bp_end", 0, 2, 0, 0);

        // Overrun: hold code 4 stalled, then hit line 3 repeatedly (ptr=3)
        out_ready = 1'b0;
        req_in = 8'h10; tick(); chk_out("ov_load", 0, 2, 1, 0);
        req_in = 8'h00; tick(); chk_out("ov_hold4", 1, 4, 0, 0);
        req_in = 8'h08; tick(); chk_out("ov_first", 1, 4, 1, 0);
        req_in = 8'h08; tick(); chk_out("ov_second", 1, 4, 1, 1);
        req_in = 8'h08; tick(); chk_out("ov_third", 1, 4, 1, 1);
        req_in = 8'h00;
        out_ready = 1'b1;
        tick();                 chk_out("ov_3", 1, 3, 0, 1);
        tick();                 chk_out("ov_end", 0, 3, 0, 1);
        tick();                 chk_out("ov_idle", 0, 3, 0, 1);

        // Set wins over the grant clear of the same bit; no overrun
        do_reset();
        out_ready = 1'b1;
        req_in = 8'h08; tick(); chk_out("sw_load", 0, 0, 1, 0);
        req_in = 8'h08; tick(); chk_out("sw_grant", 1, 3, 1, 0);
        req_in = 8'h00; tick(); chk_out("sw_again", 1, 3, 0, 0);
        tick();                 chk_out("sw_end", 0, 3, 0, 0);

        // Async reset mid-HOLD with four pending (ptr=4, so line 0 is granted first)
        out_ready = 1'b0;
        req_in = 8'h01; tick(); chk_out("ar_load", 0, 3, 1, 0);
        req_in = 8'h0F; tick(); chk_out("ar_hold0", 1, 0, 4, 0);
        req_in = 8'h01; tick(); chk_out("ar_ovr", 1, 0, 4, 1);
        req_in = 8'h00;
        #2 rst_n = 1'b0;
        #1;                     chk_out("ar_drop", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();             chk_out("ar_quiet", 0, 0, 0, 0);
        end
        req_in = 8'h80; tick(); chk_out("ar_new", 0, 0, 1, 0);
        req_in = 8'h00; tick(); chk_out("ar_new7", 1, 7, 0, 0);
        tick();                 chk_out("ar_newend", 0, 7, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_encode8.md
Name: rr_encode8

Overview:
- Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 decode path.
- Captures single-cycle event pulses on 8 one-hot request lines into a pending register.
- Emits each pending event as a 3-bit binary code through a valid/ready output handshake, using round-robin priority so that no line starves.
- Sits between the lab's event sources (buttons, comparator strobes) and any consumer of a binary index.

Parameters:
N_REQ, 8, number of request lines; fixed at 8 (a 3-bit code); other values unsupported.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_in  input  8  event pulses; bit i high for one or more cycles = one event per high cycle
out_ready  input  1  consumer accepts out_code this cycle when out_valid=1
out_valid  output  1  out_code holds a valid encoded event
out_code  output  3  binary index of the granted request line
pend_cnt  output  4  popcount of the pending register (0..8)
overrun  output  1  sticky: an event was lost because its pending bit was already set

Behaviour:
- Reset (rst_n low, asynchronous): pending=8'h00, state=IDLE, out_valid=0, out_code=3'd0, ptr=3'd0, pend_cnt=0, overrun=0. Reset mid-transfer discards all pending events and any held code.
- Pending update, every cycle: pending <= (pending & ~load_mask) | req_in.
  - load_mask is the one-hot bit granted this cycle, or 0 if nothing is granted.
  - If req_in[i] and load_mask[i] are both set in the same cycle, pending[i] ends at 1. The set is a new event and wins.
- Selection:
  - Combinational search over the registered pending value for the first set bit at index ptr, ptr+1, ... 7, 0, ... ptr-1 (wrap-around).
  - Requests arriving in the current cycle are not eligible until the next cycle.
- FSM states:
  - IDLE: out_valid=0. If pending!=0, load out_code=selected index, clear that pending bit, set ptr=(index+1) mod 8, set out_valid=1, go to HOLD. Otherwise stay in IDLE.
  - HOLD: out_valid=1 and out_code stable until a handshake (out_valid & out_ready).
    - On handshake with pending!=0: load the next selection in the same cycle and stay in HOLD. This gives back-to-back throughput of one code per cycle.
    - On handshake with pending==0: out_valid=0, go to IDLE. out_code keeps its last value.
    - Without a handshake: hold state and values; pending continues to accumulate.
- Latency: a req_in pulse at edge n gives pending set after edge n; out_valid=1 after edge n+1 when the block is IDLE. Minimum latency is 2 cycles.
- Pointer wrap: a grant of index 7 sets ptr=0.
- Overrun:
  - Set when req_in[i]=1 while pending[i]=1 and load_mask[i]=0. The earlier event is merged and lost.
  - Cleared only by reset.
  - A req on the line currently held in out_code is not an overrun; it becomes a new pending event.
- pend_cnt is registered. It equals the popcount of pending after each edge, 0..8, and needs 4 bits.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset then idle: rst_n low, then high with req_in=0 for 10 cycles -> out_valid=0, out_code=0, pend_cnt=0, overrun=0 throughout.
- Single event: req_in=8'h20 for 1 cycle, out_ready=1 -> out_valid=1 with out_code=5 two cycles later, for exactly 1 cycle; ptr becomes 6; pend_cnt reads 1 then 0.
- Round-robin with wrap: with ptr=6, pulse req_in=8'hC3 once, out_ready=1 -> codes 6,7,0,1 on consecutive cycles; out_valid high 4 cycles, then low.
- Backpressure: req_in=8'h05 once, out_ready=0 for 5 cycles, then 1 -> out_code=0 held stable with out_valid=1 for 5 cycles; then codes 0 and 2 on successive cycles; pend_cnt=1 while stalled.
- Overrun and set-wins: pulse req_in[3] twice while pending[3]=1 and stalled -> overrun=1 and only one code 3 emitted. Pulse req_in[3] in the same cycle bit 3 is loaded -> a second code 3 is emitted, and overrun is unchanged by that pulse.
- Async reset mid-HOLD: assert rst_n low between edges with out_valid=1 and pend_cnt=4 -> out_valid, pend_cnt and overrun drop to 0 immediately; no codes appear after release until a new req_in.
